riscv_ifu: RTL and testbench

Instruction Fetch Unit; the producing end of the fetch-to-decode valid/ready interface that feeds the decode stage.
- Holds the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid bus.
- Buffers returned instructions, with their PCs, in a small FIFO that drives the decode stage.
- On a branch redirect, flushes all buffered and in-flight fetches and restarts fetching at the target.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/riscv_ifu_if.sv | 30 +++
 rtl/riscv_ifu_fifo.sv | 63 ++++++
 rtl/riscv_ifu.sv | 165 ++++++++++++++++
 tb/tb_riscv_ifu.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IMEM_ADDR_W      : width of a word address (byte address bits [31:2])
//   DEFAULT_RESET_PC : default word address fetched first after reset
//   ifu_entry_t      : one decoded-stage slot, instruction plus its word PC
package riscv_pkg;

  localparam int IMEM_ADDR_W = 30;

  localparam logic [IMEM_ADDR_W-1:0] DEFAULT_RESET_PC = 30'h0;

  typedef struct packed {
    logic [31:0]            instr;
    logic [IMEM_ADDR_W-1:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/riscv_ifu_if.sv
// Fetch unit bus bundle: the instruction-memory req/gnt/rvalid channel and the
// fetch-to-decode valid/ready channel.
//   master : the fetch unit (drives imem_req_o/imem_addr_o, valid_o/instr_o/pc_o)
//   slave  : the environment (memory and decode stage)
// Signal names keep the fetch unit's point of view (_o = driven by the IFU).
interface riscv_ifu_if;
  import riscv_pkg::*;

  logic                   imem_req_o;
  logic [IMEM_ADDR_W-1:0] imem_addr_o;
  logic                   imem_gnt_i;
  logic                   imem_rvalid_i;
  logic [31:0]            imem_rdata_i;

  logic                   valid_o;
  logic                   ready_i;
  logic [31:0]            instr_o;
  logic [IMEM_ADDR_W-1:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i
  );

endinterface

// File: rtl/riscv_ifu_fifo.sv
// Small synchronous FIFO with occupancy count and flush.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   flush_i         : empties the FIFO; takes priority over push/pop
//   push_i, data_i  : write one entry (ignored when full and not popping)
//   pop_i           : drop the head entry (ignored when empty)
//   data_o          : head entry, all zeros while empty
//   count_o         : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module riscv_ifu_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // was written, and data_o is forced to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/riscv_ifu.sv
// Instruction fetch unit: producer side of the fetch-to-decode handshake.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   clear_i         : redirect (taken branch/jump); flushes buffered and
//                     in-flight fetches
//   target_i        : redirect word address, sampled while clear_i=1
//   bus (master)    : imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/
//                     imem_rdata_i to instruction memory, and
//                     valid_o/ready_i/instr_o/pc_o to the decode stage
// Optional (macro RISCV_IFU_PERF_EN):
//   perf_fetched_o  : count of instructions accepted by decode
//   perf_flushed_o  : count of instructions discarded by redirects
// A request is issued only while in-flight plus buffered instructions leave
// room in the output FIFO, so a response can always be stored.
module riscv_ifu
  import riscv_pkg::*;
#(
  parameter logic [IMEM_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                     DEPTH    = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   clear_i,
  input  logic [IMEM_ADDR_W-1:0] target_i,
  riscv_ifu_if.master            bus
`ifdef RISCV_IFU_PERF_EN
  ,
  output logic [31:0]            perf_fetched_o,
  output logic [31:0]            perf_flushed_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [IMEM_ADDR_W-1:0] pc_q;
  logic [IMEM_ADDR_W-1:0] inflight_pc;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          kill_cnt_q;
  logic [CW:0]            credit_used;
  logic                   req;
  logic                   grant;
  logic                   rsp_fire;
  logic                   rsp_keep;
  logic                   valid;
  logic                   out_pop;
  ifu_entry_t             out_entry;
  ifu_entry_t             head;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  // reset_ni gates the request so the bus is quiet while reset is held.
  assign req   = (credit_used < (CW+1)'(DEPTH)) && !clear_i && reset_ni;
  assign grant = req && bus.imem_gnt_i;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;

  // ---------------------------------------------------------------------------
  // Response side. A stray rvalid with nothing in flight is ignored.
  // ---------------------------------------------------------------------------
  assign rsp_fire = bus.imem_rvalid_i && (outstanding != '0);
  assign rsp_keep = rsp_fire && (kill_cnt_q == '0) && !clear_i;

  assign out_entry = '{instr: bus.imem_rdata_i, pc: inflight_pc};

  // PCs of granted requests, popped in order as responses return. Its count
  // is the number of outstanding requests.
  riscv_ifu_fifo #(
    .WIDTH (IMEM_ADDR_W),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .flush_i (1'b0),
    .push_i  (grant),
    .data_i  (pc_q),
    .pop_i   (rsp_fire),
    .data_o  (inflight_pc),
    .count_o (outstanding)
  );

  // Instructions waiting for decode.
  riscv_ifu_fifo #(
    .WIDTH ($bits(ifu_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .flush_i (clear_i),
    .push_i  (rsp_keep),
    .data_i  (out_entry),
    .pop_i   (out_pop),
    .data_o  (head),
    .count_o (fifo_count)
  );

  assign valid   = (fifo_count != '0);
  assign out_pop = valid && bus.ready_i && !clear_i;

  assign bus.valid_o = valid;
  assign bus.instr_o = head.instr;
  assign bus.pc_o    = head.pc;

  // ---------------------------------------------------------------------------
  // Fetch PC and kill counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= RESET_PC;
      kill_cnt_q <= '0;
    end else if (clear_i) begin
      pc_q <= target_i;
      // Every request still in flight is stale after a redirect. The
      // outstanding count already includes responses an earlier redirect
      // marked for killing, so it is the accumulated total to discard; a
      // response landing in this very cycle is dropped here directly.
      kill_cnt_q <= outstanding - CW'(rsp_fire);
    end else begin
      if (grant) pc_q <= pc_q + 1'b1;
      if (rsp_fire && (kill_cnt_q != '0)) kill_cnt_q <= kill_cnt_q - 1'b1;
    end
  end

`ifdef RISCV_IFU_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;
  logic [31:0] flush_amt;

  // NOTE: combinational outputs get a default before any branch so no path
  // leaves them unassigned, which would infer a latch.
  always_comb begin
    flush_amt = '0;
    if (clear_i) begin
      flush_amt = 32'(fifo_count) + 32'(rsp_fire);
    end else if (rsp_fire && (kill_cnt_q != '0)) begin
      flush_amt = 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(out_pop);
      flushed_q <= flushed_q + flush_amt;
    end
  end

  assign perf_fetched_o = fetched_q;
  assign perf_flushed_o = flushed_q;
`endif

  // Memory must never answer a request that was not made.
  rvalid_needs_request: assert property (
    @(posedge clk_i) disable iff (!reset_ni)
    bus.imem_rvalid_i |-> (outstanding != '0)
  ) else $error("riscv_ifu: imem_rvalid_i with no outstanding request");

endmodule

// File: tb/tb_riscv_ifu.sv
// Self-checking bench for riscv_ifu. A behavioural memory answers grants after
// a programmable latency; a reference fetch stream (next expected PC, queue of
// expected {instr, pc}) is advanced on every grant and wiped on every redirect,
// and a separate monitor pops it on every decode handshake.
module tb_riscv_ifu;
  import riscv_pkg::*;

  localparam logic [29:0] RST_PC = 30'h100;
  localparam int          DEPTH  = 2;

  logic        clk_i    = 1'b0;
  logic        reset_ni = 1'b0;
  logic        clear_i  = 1'b0;
  logic [29:0] target_i = '0;

  riscv_ifu_if bus_if ();

`ifdef RISCV_IFU_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  riscv_ifu #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clear_i (clear_i),
    .target_i(target_i),
    .bus     (bus_if)
`ifdef RISCV_IFU_PERF_EN
    ,
    .perf_fetched_o(perf_fetched),
    .perf_flushed_o(perf_flushed)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[13:0], a[29:12]} ^ 32'hC0DE_5EED;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t        mem_q[$];
  ifu_entry_t  exp_q[$];
  int          last_due        = 0;
  int          lat_cfg         = 1;      // 0 = random 1..3
  logic [29:0] model_pc        = RST_PC;
  int          grant_cnt       = 0;
  int          fetched_cnt     = 0;
  int          model_flushed   = 0;
  int          first_grant_cyc = -1;
  int          first_valid_cyc = -1;
  logic [29:0] first_pc_after_clear = '0;
  bit          await_first_pc  = 1'b0;

  // ---------------------------------------------------------------------------
  // Memory: answers in order, at least one cycle after the grant
  // ---------------------------------------------------------------------------
  initial begin
    bus_if.imem_rvalid_i = 1'b0;
    bus_if.imem_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_ni) begin
        bus_if.imem_rvalid_i = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        bus_if.imem_rvalid_i = 1'b1;
        bus_if.imem_rdata_i  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        bus_if.imem_rvalid_i = 1'b0;
        bus_if.imem_rdata_i  = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request tracker: advances the reference stream, pushes expectations
  // ---------------------------------------------------------------------------
  int trk_lat;
  int trk_due;

  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (reset_ni) begin
        if (clear_i) begin
          check("no_req_in_clear", bus_if.imem_req_o, 1'b0);
          model_flushed += exp_q.size();
          exp_q.delete();
          model_pc       = target_i;
          await_first_pc = 1'b1;
        end else if (bus_if.imem_req_o && bus_if.imem_gnt_i) begin
          check("fetch_addr", bus_if.imem_addr_o, model_pc);
          exp_q.push_back('{instr: mem_word(model_pc), pc: model_pc});
          trk_lat = (lat_cfg == 0) ? int'($urandom_range(1, 3)) : lat_cfg;
          trk_due = cyc + trk_lat;
          if (trk_due <= last_due) trk_due = last_due + 1;
          last_due = trk_due;
          mem_q.push_back('{due: trk_due, data: mem_word(bus_if.imem_addr_o)});
          if (first_grant_cyc < 0) first_grant_cyc = cyc;
          grant_cnt++;
          model_pc = model_pc + 30'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: pops and compares on every decode handshake
  // ---------------------------------------------------------------------------
  bit         clr_prev = 1'b0;
  ifu_entry_t mon_e;

  initial begin
    forever begin
      @(negedge clk_i);
      #3;
      if (!reset_ni) begin
        clr_prev = 1'b0;
      end else begin
        if (bus_if.valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (clr_prev) check("valid_after_clear", bus_if.valid_o, 1'b0);
        if (bus_if.valid_o && bus_if.ready_i && !clear_i) begin
          fetched_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_instr", bus_if.valid_o, 1'b0);
          end else begin
            mon_e = exp_q.pop_front();
            check("instr", bus_if.instr_o, mon_e.instr);
            check("pc", bus_if.pc_o, mon_e.pc);
            if (await_first_pc) begin
              first_pc_after_clear = bus_if.pc_o;
              await_first_pc       = 1'b0;
            end
          end
        end
        clr_prev = clear_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk_i);
    #4;
    reset_ni = 1'b0;
    clear_i  = 1'b0;
    #1;
    check("rst_valid", bus_if.valid_o, 1'b0);
    check("rst_req", bus_if.imem_req_o, 1'b0);
    check("rst_instr", bus_if.instr_o, 32'h0);
    check("rst_pc", bus_if.pc_o, 30'h0);
`ifdef RISCV_IFU_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_flushed", perf_flushed, 32'h0);
`endif
    mem_q.delete();
    exp_q.delete();
    bus_if.imem_rvalid_i = 1'b0;
    model_pc        = RST_PC;
    last_due        = cyc;
    first_grant_cyc = -1;
    first_valid_cyc = -1;
    fetched_cnt     = 0;
    model_flushed   = 0;
    await_first_pc  = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic drain();
    clear_i           = 1'b0;
    bus_if.imem_gnt_i = 1'b0;
    bus_if.ready_i    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (mem_q.size() == 0) break;
    end
    repeat (4) @(negedge clk_i);
    check("drain_mem_idle", mem_q.size(), 0);
    check("drain_all_delivered", exp_q.size(), 0);
    check("drain_valid_low", bus_if.valid_o, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int  g0;
  bit  found;
  logic [29:0] a0;

  initial begin
    bus_if.imem_gnt_i = 1'b0;
    bus_if.ready_i    = 1'b0;

    // 1: streaming from RESET_PC with a 1-cycle memory
    do_reset();
    lat_cfg           = 1;
    bus_if.imem_gnt_i = 1'b1;
    bus_if.ready_i    = 1'b1;
    repeat (20) @(negedge clk_i);
    check("t1_first_valid_latency", first_valid_cyc - first_grant_cyc, 2);

    // 2: decode stalled -> credit limits grants to DEPTH
    do_reset();
    bus_if.ready_i    = 1'b0;
    bus_if.imem_gnt_i = 1'b1;
    g0 = grant_cnt;
    repeat (10) @(negedge clk_i);
    #4;
    check("t2_grants_while_stalled", grant_cnt - g0, DEPTH);
    check("t2_req_off", bus_if.imem_req_o, 1'b0);
    check("t2_head_pc", bus_if.pc_o, RST_PC);
    @(negedge clk_i);
    bus_if.ready_i = 1'b1;
    repeat (10) @(negedge clk_i);

    // 3: no grant -> address holds
    bus_if.imem_gnt_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #4;
    a0 = bus_if.imem_addr_o;
    check("t3_addr_is_model_pc", a0, model_pc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      #4;
      check("t3_req_held", bus_if.imem_req_o, 1'b1);
      check("t3_addr_held", bus_if.imem_addr_o, a0);
    end
    @(negedge clk_i);
    bus_if.imem_gnt_i = 1'b1;
    repeat (8) @(negedge clk_i);

    // 4: redirect with two requests in flight on a 3-cycle memory
    do_reset();
    lat_cfg           = 3;
    bus_if.imem_gnt_i = 1'b1;
    bus_if.ready_i    = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      #1;
      if (mem_q.size() >= 2) begin
        clear_i  = 1'b1;
        target_i = 30'h200;
        found    = 1'b1;
        break;
      end
    end
    check("t4_two_in_flight", found, 1'b1);
    @(negedge clk_i);
    clear_i = 1'b0;
    #4;
    check("t4_valid_low_after_clear", bus_if.valid_o, 1'b0);
    repeat (20) @(negedge clk_i);
    check("t4_first_pc_after_clear", first_pc_after_clear, 30'h200);

    // 5: redirect coinciding with a response and a decode handshake
    do_reset();
    lat_cfg = 1;
    found   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      #1;
      if (bus_if.imem_rvalid_i && bus_if.valid_o) begin
        clear_i  = 1'b1;
        target_i = 30'h300;
        found    = 1'b1;
        break;
      end
    end
    check("t5_collision_found", found, 1'b1);
    @(negedge clk_i);
    clear_i = 1'b0;
    #4;
    check("t5_empty_after_clear", bus_if.valid_o, 1'b0);
    repeat (10) @(negedge clk_i);
    check("t5_first_pc_after_clear", first_pc_after_clear, 30'h300);

    // Randomised traffic: grants, stalls, redirects, variable latency
    lat_cfg = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_i);
      bus_if.imem_gnt_i = ($urandom_range(0, 3) != 0);
      bus_if.ready_i    = ($urandom_range(0, 3) != 0);
      clear_i           = ($urandom_range(0, 24) == 0);
      target_i          = 30'($urandom);
    end
    drain();
`ifdef RISCV_IFU_PERF_EN
    check("rand_perf_fetched", perf_fetched, 32'(fetched_cnt));
    check("rand_perf_flushed", perf_flushed, 32'(model_flushed));

    // 6: 20 accepted, then a redirect that flushes buffered work
    do_reset();
    lat_cfg           = 1;
    bus_if.imem_gnt_i = 1'b1;
    bus_if.ready_i    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (fetched_cnt >= 20) break;
    end
    bus_if.ready_i    = 1'b0;
    bus_if.imem_gnt_i = 1'b0;
    repeat (4) @(negedge clk_i);
    clear_i  = 1'b1;
    target_i = 30'h40;
    @(negedge clk_i);
    clear_i = 1'b0;
    drain();
    check("t6_perf_fetched", perf_fetched, 32'd20);
    check("t6_perf_flushed", perf_flushed, 32'(model_flushed));
    bus_if.imem_gnt_i = 1'b1;
    repeat (5) @(negedge clk_i);
`endif

    // Reset asserted mid-stream clears everything immediately
    bus_if.imem_gnt_i = 1'b1;
    bus_if.ready_i    = 1'b1;
    repeat (6) @(negedge clk_i);
    do_reset();
    repeat (6) @(negedge clk_i);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
